// File: rtl/aes_stream_ctrl.sv
// Sequencer between a valid/ready block stream and the aes core: one core operation per block.
// Latency: accept at N, core_load_o at N+1, out_valid_o one cycle after the core's ready edge.
// Backpressure: in_ready_o drops while busy, while a key load is offered, or while the output register is stalled.
module aes_stream_ctrl #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid_i,
    input  logic [127:0]     key_i,
    input  logic             dir_i,
    output logic             key_ready_o,
    input  logic             in_valid_i,
    input  logic [127:0]     in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [127:0]     out_data_o,
    input  logic             out_ready_i,
    output logic             core_load_o,
    output logic             core_decrypt_o,
    output logic [127:0]     core_key_o,
    output logic [127:0]     core_data_o,
    input  logic             core_ready_i,
    input  logic [127:0]     core_data_i,
    output logic             busy_o,
    output logic             err_timeout_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state;
    logic          key_loaded;
    logic          ready_q;
    logic [TW-1:0] tmo_cnt;
    logic          in_fire;
    logic          done;

    assign key_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    // A pending key load takes the cycle; a stalled output register blocks new launches.
    assign in_ready_o  = key_ready_o & key_loaded & ~key_valid_i & (~out_valid_o | out_ready_i);
    assign in_fire     = in_valid_i & in_ready_o;
    assign done        = (state == WAIT) & core_ready_i & ~ready_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            key_loaded     <= 1'b0;
            ready_q        <= 1'b0;
            tmo_cnt        <= '0;
            core_load_o    <= 1'b0;
            core_decrypt_o <= 1'b0;
            core_key_o     <= '0;
            core_data_o    <= '0;
            out_valid_o    <= 1'b0;
            out_data_o     <= '0;
            err_timeout_o  <= 1'b0;
            blk_cnt_o      <= '0;
        end else begin
            ready_q     <= core_ready_i;
            core_load_o <= 1'b0;
            if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (key_valid_i) begin
                        core_key_o     <= key_i;
                        core_decrypt_o <= dir_i;
                        key_loaded     <= 1'b1;
                        err_timeout_o  <= 1'b0;
                    end else if (in_fire) begin
                        core_data_o <= in_data_i;
                        core_load_o <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        out_data_o  <= core_data_i;
                        out_valid_o <= 1'b1;
                        blk_cnt_o   <= blk_cnt_o + CNT_W'(1);
                        state       <= IDLE;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        // Hung core: drop the block without counting it.
                        err_timeout_o <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl with an xor core model and an output scoreboard.
module tb_aes_stream_ctrl;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             key_valid = 1'b0;
    logic [127:0]     key = '0;
    logic             dir = 1'b0;
    logic             key_ready;
    logic             in_valid = 1'b0;
    logic [127:0]     in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [127:0]     out_data;
    logic             out_ready = 1'b1;
    logic             core_load;
    logic             core_decrypt;
    logic [127:0]     core_key;
    logic [127:0]     core_dat;
    logic             core_ready = 1'b0;
    logic [127:0]     core_rdata = '0;
    logic             busy;
    logic             err_timeout;
    logic [CNT_W-1:0] blk_cnt;

    int               checks = 0;
    int               errors = 0;
    int               loads = 0;
    int               mcnt = 0;
    bit               hang = 1'b0;
    logic [CNT_W-1:0] delivered = '0;
    logic [127:0]     cur_key = '0;
    logic [127:0]     exp_q[$];

    aes_stream_ctrl #(.TIMEOUT_CYC(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .key_valid_i(key_valid), .key_i(key), .dir_i(dir), .key_ready_o(key_ready),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
        .core_load_o(core_load), .core_decrypt_o(core_decrypt), .core_key_o(core_key),
        .core_data_o(core_dat), .core_ready_i(core_ready), .core_data_i(core_rdata),
        .busy_o(busy), .err_timeout_o(err_timeout), .blk_cnt_o(blk_cnt)
    );

    always #5 clk = ~clk;

    // Core model: ready rises 10 cycles after load, result is data ^ key.
    always @(posedge clk) begin
        if (core_load) begin
            mcnt       <= 10;
            core_ready <= 1'b0;
            core_rdata <= core_dat ^ core_key;
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end else if (mcnt == 1) begin
            mcnt       <= 0;
            core_ready <= !hang;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on every output handshake.
    always @(negedge clk) begin
        if (core_load) loads++;
        if (reset && out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL out_unexpected observed=%h expected=none", out_data);
            end
            if (exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q.pop_front());
                chk("out_blk_cnt", 128'(blk_cnt), 128'(CNT_W'(delivered + 1'b1)));
                delivered = delivered + 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k, input logic d);
        key_valid = 1'b1;
        key       = k;
        dir       = d;
        step();
        key_valid = 1'b0;
        cur_key   = k;
    endtask

    task automatic send(input logic [127:0] d, input bit expect_out);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        if (expect_out) exp_q.push_back(d ^ cur_key);
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("send_accept_timeout", 128'(n), 128'(0));
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(exp_q.size()), 128'(0));
        step();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int   l0;
        int   n;
        int   seen;
        logic [CNT_W-1:0] cnt0;
        logic [127:0] k2;
        logic [127:0] d2;
        logic [127:0] a3;
        logic [127:0] k4;
        logic [127:0] d4;

        k2 = 128'h3cdba6b3993e0c871c0d5e24de47b706;
        d2 = 128'he382e4bfe020dde6a6c8bc63ed1f049c;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_core_load", 128'(core_load), 128'(0));
        chk("rst_err", 128'(err_timeout), 128'(0));
        chk("rst_blk_cnt", 128'(blk_cnt), 128'(0));
        chk("rst_core_key", core_key, 128'(0));
        chk("rst_core_data", core_dat, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        step();
        reset = 1'b1;

        // Blocks offered before any key are ignored.
        l0       = loads;
        in_valid = 1'b1;
        in_data  = rnd128();
        @(negedge clk);
        chk("nokey_in_ready", 128'(in_ready), 128'(0));
        repeat (5) step();
        in_valid = 1'b0;
        chk("nokey_no_load", 128'(loads - l0), 128'(0));
        chk("nokey_busy", 128'(busy), 128'(0));

        // Single decrypt block, latency and pulse width.
        load_key(k2, 1'b1);
        chk("t2_key", core_key, k2);
        chk("t2_dir", 128'(core_decrypt), 128'(1));
        l0 = loads;
        send(d2, 1'b1);
        chk("t2_load_pulse", 128'(core_load), 128'(1));
        chk("t2_core_data", core_dat, d2);
        step();
        n = 1;
        chk("t2_load_single", 128'(core_load), 128'(0));
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        chk("t2_latency", 128'(n), 128'(12));
        wait_drain("t2_drain");
        chk("t2_loads", 128'(loads - l0), 128'(1));
        chk("t2_cnt", 128'(blk_cnt), 128'(1));

        // Reset in the middle of WAIT.
        send(rnd128(), 1'b1);
        repeat (4) step();
        chk("t1_busy_pre", 128'(busy), 128'(1));
        reset = 1'b0;
        @(negedge clk);
        chk("t1_busy", 128'(busy), 128'(0));
        chk("t1_core_load", 128'(core_load), 128'(0));
        chk("t1_out_valid", 128'(out_valid), 128'(0));
        chk("t1_blk_cnt", 128'(blk_cnt), 128'(0));
        chk("t1_core_key", core_key, 128'(0));
        chk("t1_core_data", core_dat, 128'(0));
        exp_q.delete();
        delivered = '0;
        step();
        reset = 1'b1;
        l0 = loads;
        repeat (20) step();
        chk("t1_no_load", 128'(loads - l0), 128'(0));
        chk("t1_no_out", 128'(out_valid), 128'(0));
        chk("t1_in_ready", 128'(in_ready), 128'(0));

        // Output stall with a second block held on the input.
        load_key(rnd128(), 1'b0);
        chk("t3_dir", 128'(core_decrypt), 128'(0));
        out_ready = 1'b0;
        l0 = loads;
        a3 = rnd128();
        send(a3, 1'b1);
        in_valid = 1'b1;
        in_data  = rnd128();
        exp_q.push_back(in_data ^ cur_key);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen += int'(in_ready);
        end
        chk("t3_in_ready_held", 128'(seen), 128'(0));
        chk("t3_loads", 128'(loads - l0), 128'(1));
        chk("t3_stable", out_data, a3 ^ cur_key);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_in_ready_release", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        wait_drain("t3_drain");
        chk("t3_loads_total", 128'(loads - l0), 128'(2));

        // Key load and block offered in the same IDLE cycle.
        k4 = rnd128();
        d4 = rnd128();
        key_valid = 1'b1;
        key       = k4;
        dir       = 1'b1;
        in_valid  = 1'b1;
        in_data   = d4;
        @(negedge clk);
        chk("t4_keywins", 128'(in_ready), 128'(0));
        step();
        key_valid = 1'b0;
        cur_key   = k4;
        exp_q.push_back(d4 ^ k4);
        @(negedge clk);
        chk("t4_in_ready_after", 128'(in_ready), 128'(1));
        chk("t4_key", core_key, k4);
        step();
        in_valid = 1'b0;
        wait_drain("t4_drain");

        // Hung core: timeout after 64 WAIT cycles.
        hang = 1'b1;
        cnt0 = blk_cnt;
        l0   = loads;
        send(rnd128(), 1'b0);
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk("t5_busy_cycles", 128'(n), 128'(65));
        chk("t5_err", 128'(err_timeout), 128'(1));
        chk("t5_cnt", 128'(blk_cnt), 128'(cnt0));
        chk("t5_no_out", 128'(out_valid), 128'(0));
        repeat (3) step();
        chk("t5_err_sticky", 128'(err_timeout), 128'(1));
        hang = 1'b0;
        load_key(rnd128(), 1'b0);
        chk("t5_err_clear", 128'(err_timeout), 128'(0));

        // Counter wrap with back-to-back blocks.
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_q.delete();
        delivered = '0;
        load_key(rnd128(), 1'b0);
        out_ready = 1'b1;
        l0 = loads;
        for (int i = 0; i < 5; i++) send(rnd128(), 1'b1);
        wait_drain("t6_drain");
        chk("t6_cnt", 128'(blk_cnt), 128'(1));
        chk("t6_loads", 128'(loads - l0), 128'(5));

        chk("final_q_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
